// File: rtl/sfft_sample_sequencer.sv
// Front end for SFFT_Pipeline: buffers audio samples, presents each one for a settle window,
// pulses advance, and hands completed frames to the peak finder with a valid/ack handshake.
//
// state      | meaning
// IDLE       | waiting for enable and a buffered sample
// SETTLE     | sample held on sfft_sample for CALC_CYCLES cycles
// ADVANCE    | one-cycle advance pulse, sample counter steps
// FRAME_WAIT | frame complete, waiting for pipeline output_valid
// FRAME_HOLD | frame_valid held until peak finder acks
module sfft_sample_sequencer #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int NFFT         = 8,
    parameter int CALC_CYCLES  = 20,
    parameter int FIFO_DEPTH   = 4,
    parameter int OVR_WIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [SAMPLE_WIDTH-1:0]       sample_in,
    input  logic                          sample_valid,
    output logic [SAMPLE_WIDTH-1:0]       sfft_sample,
    output logic                          sfft_advance,
    input  logic                          sfft_output_valid,
    output logic                          frame_valid,
    input  logic                          frame_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [OVR_WIDTH-1:0]          overrun_count,
    output logic                          busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam int NW = $clog2(NFFT);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(CALC_CYCLES - 1);
    localparam logic [NW-1:0] SAMPLE_LAST = NW'(NFFT - 1);
    localparam logic [LW-1:0] DEPTH       = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ADVANCE,
        FRAME_WAIT,
        FRAME_HOLD
    } state_t;

    state_t state, state_next;

    logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [CW-1:0]           settle_cnt;
    logic [NW-1:0]           sample_cnt;
    logic                    full, empty, pop, push, drop;

    assign full  = (fifo_level == DEPTH);
    assign empty = (fifo_level == '0);
    assign pop   = (state == IDLE) && enable && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    assign push  = sample_valid && (!full || pop);
    assign drop  = sample_valid && !push;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_level    <= '0;
            overrun_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sample_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
            if (drop && (overrun_count != '1)) begin
                overrun_count <= overrun_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            sample_cnt   <= '0;
            sfft_sample  <= '0;
            sfft_advance <= 1'b0;
            frame_valid  <= 1'b0;
        end else begin
            state        <= state_next;
            sfft_advance <= (state_next == ADVANCE);
            frame_valid  <= (state_next == FRAME_HOLD);
            if (pop) begin
                sfft_sample <= mem[rd_ptr];
                settle_cnt  <= '0;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (state == ADVANCE) begin
                sample_cnt <= (sample_cnt == SAMPLE_LAST) ? '0 : sample_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:       if (pop) state_next = SETTLE;
            SETTLE:     if (settle_cnt == SETTLE_LAST) state_next = ADVANCE;
            ADVANCE:    state_next = (sample_cnt == SAMPLE_LAST) ? FRAME_WAIT : IDLE;
            FRAME_WAIT: if (sfft_output_valid) state_next = FRAME_HOLD;
            FRAME_HOLD: if (frame_ack) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sfft_sample_sequencer.sv
// Self-checking bench for sfft_sample_sequencer: directed scenarios plus random traffic,
// compared every cycle against a queue/countdown model of the sequencing rules.
module tb_sfft_sample_sequencer;
    localparam int SW      = 24;
    localparam int NFFT    = 8;
    localparam int CALC    = 20;
    localparam int DEPTH   = 4;
    localparam int OVRW    = 8;
    localparam int OVR_MAX = (1 << OVRW) - 1;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       enable = 1'b0;
    logic [SW-1:0]              sample_in = '0;
    logic                       sample_valid = 1'b0;
    logic [SW-1:0]              sfft_sample;
    logic                       sfft_advance;
    logic                       sfft_output_valid = 1'b0;
    logic                       frame_valid;
    logic                       frame_ack = 1'b0;
    logic [$clog2(DEPTH):0]     fifo_level;
    logic [OVRW-1:0]            overrun_count;
    logic                       busy;

    int errors = 0;
    int checks = 0;

    sfft_sample_sequencer #(
        .SAMPLE_WIDTH(SW), .NFFT(NFFT), .CALC_CYCLES(CALC), .FIFO_DEPTH(DEPTH), .OVR_WIDTH(OVRW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sfft_sample(sfft_sample), .sfft_advance(sfft_advance),
        .sfft_output_valid(sfft_output_valid), .frame_valid(frame_valid), .frame_ack(frame_ack),
        .fifo_level(fifo_level), .overrun_count(overrun_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: a queue for the FIFO, and "work" counts the remaining cycles of the current
    // sample (CALC settle cycles followed by the advance cycle, which is work==1).
    logic [SW-1:0] mq[$];
    logic [SW-1:0] m_smp = '0;
    int  work = 0;
    int  nadv = 0;
    int  m_ovr = 0;
    bit  m_wait = 0;
    bit  m_hold = 0;

    function automatic bit m_busy();
        return (work > 0) || m_wait || m_hold;
    endfunction

    task automatic model_step();
        bit pop, was_full;
        if (reset) begin
            mq.delete();
            m_smp = '0; work = 0; nadv = 0; m_ovr = 0; m_wait = 0; m_hold = 0;
            return;
        end
        pop      = !m_busy() && enable && (mq.size() > 0);
        was_full = (mq.size() == DEPTH);
        if (pop) m_smp = mq.pop_front();
        if (sample_valid) begin
            if (!was_full || pop) mq.push_back(sample_in);
            else if (m_ovr < OVR_MAX) m_ovr++;
        end
        if (work == 1) begin
            work = 0;
            nadv = (nadv + 1) % NFFT;
            if (nadv == 0) m_wait = 1;
        end else if (work > 1) begin
            work--;
        end else if (m_wait) begin
            if (sfft_output_valid) begin m_wait = 0; m_hold = 1; end
        end else if (m_hold) begin
            if (frame_ack) m_hold = 0;
        end else if (pop) begin
            work = CALC + 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("sfft_sample", 32'(sfft_sample), 32'(m_smp));
            check("sfft_advance", 32'(sfft_advance), 32'(work == 1));
            check("frame_valid", 32'(frame_valid), 32'(m_hold));
            check("fifo_level", 32'(fifo_level), mq.size());
            check("overrun_count", 32'(overrun_count), m_ovr);
            check("busy", 32'(busy), 32'(m_busy()));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_one(input logic [SW-1:0] v);
        sample_in = v; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 3000; n++) begin
            sfft_output_valid = m_wait;
            frame_ack = m_hold;
            if (!m_busy() && mq.size() == 0) break;
            step();
        end
        sfft_output_valid = 1'b0; frame_ack = 1'b0;
        check("drain_timeout", 32'(n < 3000), 1);
    endtask

    logic [SW-1:0] vals [8] = '{24'd61, 24'd77, 24'd90, 24'd6, 24'd33, 24'd23, 24'd85, 24'd11};

    initial begin
        int pulses, peak, n, t, bad_fv, bad_adv, bad_busy;
        int times[$];
        // Reset state
        step(); step();
        reset = 1'b0;
        check("rst_sample", 32'(sfft_sample), 0);
        check("rst_advance", 32'(sfft_advance), 0);
        check("rst_frame_valid", 32'(frame_valid), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_busy", 32'(busy), 0);
        enable = 1'b1;

        // Eight spaced samples form one frame
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            push_one(vals[i]);
            for (int k = 0; k < 29; k++) begin
                if (sfft_advance) begin
                    pulses++;
                    check("adv_sample", 32'(sfft_sample), 32'(vals[i]));
                end
                step();
            end
        end
        check("adv_pulses", pulses, 8);
        check("frame_wait_busy", 32'(busy), 1);
        check("frame_wait_fv", 32'(frame_valid), 0);
        sfft_output_valid = 1'b1;
        step();
        sfft_output_valid = 1'b0;
        check("fv_after_ov", 32'(frame_valid), 1);
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        check("fv_after_ack", 32'(frame_valid), 0);
        check("idle_after_ack", 32'(busy), 0);

        // Burst of four: level peaks at 3 since the first pop overlaps the second push
        peak = 0;
        times.delete();
        for (int i = 0; i < 4; i++) begin
            sample_in = SW'(100 + i); sample_valid = 1'b1;
            step();
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        sample_valid = 1'b0;
        for (t = 0; t < 120; t++) begin
            if (sfft_advance) times.push_back(t);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            step();
        end
        check("burst_peak", peak, 3);
        check("burst_pulses", times.size(), 4);
        for (int i = 1; i < times.size(); i++) check("burst_spacing", times[i] - times[i-1], CALC + 2);
        check("burst_no_overrun", 32'(overrun_count), 0);

        // Seven back-to-back: one in flight, four buffered, two dropped
        for (int i = 0; i < 7; i++) begin
            sample_in = SW'(200 + i); sample_valid = 1'b1;
            step();
        end
        sample_valid = 1'b0;
        check("b2b_level", 32'(fifo_level), 4);
        check("b2b_overrun", 32'(overrun_count), 2);
        drain();

        // Reach FRAME_HOLD, then withhold ack while samples keep arriving
        for (n = 0; n < 2000; n++) begin
            sfft_output_valid = m_wait;
            if (m_hold) break;
            sample_in = SW'($urandom);
            sample_valid = !m_busy() && (mq.size() == 0);
            step();
        end
        sfft_output_valid = 1'b0; sample_valid = 1'b0;
        check("hold_reached", 32'(n < 2000), 1);
        check("hold_fv", 32'(frame_valid), 1);
        bad_fv = 0; bad_adv = 0;
        for (int i = 0; i < 300; i++) begin
            sample_in = SW'($urandom); sample_valid = 1'b1;
            step();
            if (!frame_valid) bad_fv++;
            if (sfft_advance) bad_adv++;
        end
        sample_valid = 1'b0;
        check("hold_fv_dropouts", bad_fv, 0);
        check("hold_adv_pulses", bad_adv, 0);
        check("hold_level_full", 32'(fifo_level), DEPTH);
        check("overrun_saturated", 32'(overrun_count), OVR_MAX);
        frame_ack = 1'b1;
        for (n = 1; n <= 60; n++) begin
            step();
            frame_ack = 1'b0;
            if (sfft_advance) break;
        end
        check("ack_to_advance", n, CALC + 2);
        drain();

        // enable low mid-settle: current advance completes, then FSM parks in IDLE
        do_reset(2);
        push_one(24'd500);
        push_one(24'd501);
        repeat (5) step();
        enable = 1'b0;
        for (n = 0; n < 40; n++) begin
            if (sfft_advance) break;
            step();
        end
        check("en_low_advance", 32'(n < 40), 1);
        bad_busy = 0;
        repeat (30) begin
            step();
            if (busy) bad_busy++;
        end
        check("en_low_idle", bad_busy, 0);
        check("en_low_level", 32'(fifo_level), 1);
        enable = 1'b1;
        step();
        check("en_pop_busy", 32'(busy), 1);
        check("en_pop_sample", 32'(sfft_sample), 501);
        drain();

        // Reset during the 5th sample's settle restarts frame counting
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            push_one(SW'(600 + i));
            repeat (24) step();
        end
        push_one(24'd604);
        repeat (5) step();
        reset = 1'b1; sample_in = 24'd999; sample_valid = 1'b1;
        step(); step();
        reset = 1'b0; sample_valid = 1'b0;
        check("midrst_sample", 32'(sfft_sample), 0);
        check("midrst_level", 32'(fifo_level), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_fv", 32'(frame_valid), 0);
        for (int i = 0; i < 8; i++) begin
            push_one(SW'(700 + i));
            repeat (24) step();
            check("newframe_busy", 32'(busy), 32'(i == 7));
        end
        drain();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 1499) == 0);
            sample_in = SW'($urandom);
            sample_valid = ($urandom_range(0, 3) == 0);
            enable = ($urandom_range(0, 7) != 0);
            sfft_output_valid = ($urandom_range(0, 5) == 0);
            frame_ack = ($urandom_range(0, 2) == 0);
            step();
        end
        reset = 1'b0; sample_valid = 1'b0; sfft_output_valid = 1'b0; frame_ack = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
